// File: rtl/ad_ip_jesd204_tpl_dac_source_mux.sv
// DAC transport-layer sample source selector.
// For each channel it picks one source: DDS, a fixed pattern, DMA, zero, PN7, PN15 or a ramp.
// The output is registered, so dac_data lags the inputs by exactly one link_clk cycle.
// Generator state is kept per channel and only advances on dac_valid cycles.
module ad_ip_jesd204_tpl_dac_source_mux #(
  parameter int unsigned NUM_CHANNELS        = 2,
  parameter int unsigned SAMPLES_PER_CHANNEL = 2,
  parameter int unsigned SAMPLE_WIDTH        = 16
) (
  input  logic                                                 link_clk,
  input  logic                                                 dac_rst,
  input  logic                                                 dac_valid,
  input  logic [NUM_CHANNELS*4-1:0]                            dac_data_sel,
  input  logic                                                 dac_dds_format,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0]                 dac_pat_data_0,
  input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0]                 dac_pat_data_1,
  input  logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_WIDTH-1:0] dds_data,
  input  logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_WIDTH-1:0] dma_data,
  output logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_WIDTH-1:0] dac_data,
  output logic                                                 dac_valid_out
);

  localparam int unsigned SPC = SAMPLES_PER_CHANNEL;
  localparam int unsigned SW  = SAMPLE_WIDTH;
  localparam int unsigned CW  = SPC * SW;
  localparam int unsigned DW  = NUM_CHANNELS * CW;

  localparam logic [3:0] SelDds     = 4'd0;
  localparam logic [3:0] SelPattern = 4'd1;
  localparam logic [3:0] SelDma     = 4'd2;
  localparam logic [3:0] SelPn7     = 4'd4;
  localparam logic [3:0] SelPn15    = 4'd5;
  localparam logic [3:0] SelRamp    = 4'd11;

  localparam logic [6:0]  Pn7Seed  = 7'h7F;
  localparam logic [14:0] Pn15Seed = 15'h7FFF;

  // The serial bit stream is collected with the first bit at the top.
  // Sample 0 has to come first, so the stream is reversed sample by sample.
  // Bit order inside each sample is left unchanged.
  function automatic logic [CW-1:0] stream_to_samples(input logic [CW-1:0] stream);
    logic [CW-1:0] samples;
    samples = '0;
    for (int unsigned k = 0; k < SPC; k++) begin
      samples[SW*k +: SW] = stream[SW*(SPC-1-k) +: SW];
    end
    return samples;
  endfunction

  // Unrolled PN7 steps for one cycle. Returns {next state, samples}.
  function automatic logic [CW+6:0] pn7_run(input logic [6:0] seed);
    logic [6:0]    s;
    logic [CW-1:0] stream;
    logic          b;
    s      = seed;
    stream = '0;
    for (int unsigned n = 0; n < CW; n++) begin
      b      = s[6] ^ s[5];
      s      = {s[5:0], b};
      stream = {stream[CW-2:0], b};
    end
    return {s, stream_to_samples(stream)};
  endfunction

  // Unrolled PN15 steps for one cycle. Returns {next state, samples}.
  function automatic logic [CW+14:0] pn15_run(input logic [14:0] seed);
    logic [14:0]   s;
    logic [CW-1:0] stream;
    logic          b;
    s      = seed;
    stream = '0;
    for (int unsigned n = 0; n < CW; n++) begin
      b      = s[14] ^ s[13];
      s      = {s[13:0], b};
      stream = {stream[CW-2:0], b};
    end
    return {s, stream_to_samples(stream)};
  endfunction

  logic [CW-1:0] ch_mux [NUM_CHANNELS];
  logic [DW-1:0] dac_data_d;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [3:0]    sel;
    logic [3:0]    sel_q;
    logic          mode_entry;
    logic [6:0]    pn7_q, pn7_d, pn7_base, pn7_next;
    logic [14:0]   pn15_q, pn15_d, pn15_base, pn15_next;
    logic [SW-1:0] ramp_q, ramp_d, ramp_base;
    logic [CW-1:0] pn7_data, pn15_data, ramp_data, ch_data;

    assign sel        = dac_data_sel[4*i +: 4];
    assign mode_entry = (sel != sel_q);

    // Switching into a generator mode restarts it from its seed this same cycle.
    always_comb begin
      pn7_base  = (mode_entry && sel == SelPn7)  ? Pn7Seed  : pn7_q;
      pn15_base = (mode_entry && sel == SelPn15) ? Pn15Seed : pn15_q;
      ramp_base = (mode_entry && sel == SelRamp) ? '0       : ramp_q;
    end

    assign {pn7_next, pn7_data}   = pn7_run(pn7_base);
    assign {pn15_next, pn15_data} = pn15_run(pn15_base);

    // Ramp samples are consecutive counts starting at the counter value.
    always_comb begin
      ramp_data = '0;
      for (int unsigned k = 0; k < SPC; k++) begin
        ramp_data[SW*k +: SW] = ramp_base + SW'(k);
      end
    end

    // A generator advances only on valid cycles while its mode is selected.
    always_comb begin
      pn7_d  = (dac_valid && sel == SelPn7)  ? pn7_next           : pn7_base;
      pn15_d = (dac_valid && sel == SelPn15) ? pn15_next          : pn15_base;
      ramp_d = (dac_valid && sel == SelRamp) ? ramp_base + SW'(SPC) : ramp_base;
    end

    // Per-sample source selection. Unused select codes produce zero.
    always_comb begin
      ch_data = '0;
      for (int unsigned k = 0; k < SPC; k++) begin
        case (sel)
          SelDds: begin
            ch_data[SW*k +: SW] = dds_data[CW*i + SW*k +: SW]
                                  ^ {~dac_dds_format, {(SW-1){1'b0}}};
          end
          SelPattern: begin
            ch_data[SW*k +: SW] = (k % 2 == 1) ? dac_pat_data_1[SW*i +: SW]
                                               : dac_pat_data_0[SW*i +: SW];
          end
          SelDma:  ch_data[SW*k +: SW] = dma_data[CW*i + SW*k +: SW];
          SelPn7:  ch_data[SW*k +: SW] = pn7_data[SW*k +: SW];
          SelPn15: ch_data[SW*k +: SW] = pn15_data[SW*k +: SW];
          SelRamp: ch_data[SW*k +: SW] = ramp_data[SW*k +: SW];
          default: ch_data[SW*k +: SW] = '0;
        endcase
      end
    end

    assign ch_mux[i] = ch_data;

    // Generator state and the previous select value, used for mode-entry detection.
    always_ff @(posedge link_clk or posedge dac_rst) begin
      if (dac_rst) begin
        sel_q  <= '0;
        pn7_q  <= Pn7Seed;
        pn15_q <= Pn15Seed;
        ramp_q <= '0;
      end else begin
        sel_q  <= sel;
        pn7_q  <= pn7_d;
        pn15_q <= pn15_d;
        ramp_q <= ramp_d;
      end
    end
  end

  // Combine the per-channel results into one output word.
  always_comb begin
    dac_data_d = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      dac_data_d[CW*c +: CW] = ch_mux[c];
    end
  end

  // Output register: one cycle of latency for the data and for the valid flag.
  always_ff @(posedge link_clk or posedge dac_rst) begin
    if (dac_rst) begin
      dac_data      <= '0;
      dac_valid_out <= 1'b0;
    end else begin
      dac_data      <= dac_data_d;
      dac_valid_out <= dac_valid;
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_source_mux.sv
// Directed bench for the DAC source mux with NUM_CHANNELS=2 and SAMPLES_PER_CHANNEL=2.
// Output packing is {ch1 s1, ch1 s0, ch0 s1, ch0 s0}.
module tb_ad_ip_jesd204_tpl_dac_source_mux;

  logic        link_clk = 1'b0;
  logic        dac_rst;
  logic        dac_valid;
  logic [7:0]  dac_data_sel;
  logic        dac_dds_format;
  logic [31:0] dac_pat_data_0;
  logic [31:0] dac_pat_data_1;
  logic [63:0] dds_data;
  logic [63:0] dma_data;
  logic [63:0] dac_data;
  logic        dac_valid_out;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state, one entry per channel
  logic [3:0]  m_sel  [2];
  logic [6:0]  m_pn7  [2];
  logic [14:0] m_pn15 [2];
  logic [15:0] m_ramp [2];

  always #5 link_clk = ~link_clk;

  ad_ip_jesd204_tpl_dac_source_mux #(
    .NUM_CHANNELS        (2),
    .SAMPLES_PER_CHANNEL (2),
    .SAMPLE_WIDTH        (16)
  ) u_dut (
    .link_clk       (link_clk),
    .dac_rst        (dac_rst),
    .dac_valid      (dac_valid),
    .dac_data_sel   (dac_data_sel),
    .dac_dds_format (dac_dds_format),
    .dac_pat_data_0 (dac_pat_data_0),
    .dac_pat_data_1 (dac_pat_data_1),
    .dds_data       (dds_data),
    .dma_data       (dma_data),
    .dac_data       (dac_data),
    .dac_valid_out  (dac_valid_out)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_sel[c]  = 4'd0;
      m_pn7[c]  = 7'h7F;
      m_pn15[c] = 15'h7FFF;
      m_ramp[c] = 16'h0000;
    end
  endtask

  // Serial reference: 32 bits per channel per cycle. Sample 0 is the first 16 bits.
  task automatic model_step(input logic v, output logic [63:0] exp);
    logic [3:0]  s;
    logic [31:0] w;
    logic [6:0]  t7;
    logic [14:0] t15;
    logic        b;
    logic [15:0] smp;
    exp = '0;
    for (int c = 0; c < 2; c++) begin
      s = dac_data_sel[4*c +: 4];
      if (s != m_sel[c]) begin
        if (s == 4'd4)  m_pn7[c]  = 7'h7F;
        if (s == 4'd5)  m_pn15[c] = 15'h7FFF;
        if (s == 4'd11) m_ramp[c] = 16'h0000;
      end
      m_sel[c] = s;
      t7  = m_pn7[c];
      t15 = m_pn15[c];
      w   = '0;
      for (int n = 0; n < 32; n++) begin
        if (s == 4'd4) begin
          b  = t7[6] ^ t7[5];
          t7 = {t7[5:0], b};
        end else begin
          b   = t15[14] ^ t15[13];
          t15 = {t15[13:0], b};
        end
        w = {w[30:0], b};
      end
      for (int k = 0; k < 2; k++) begin
        case (s)
          4'd0:      smp = dds_data[16*(2*c+k) +: 16] ^ (dac_dds_format ? 16'h0000 : 16'h8000);
          4'd1:      smp = (k == 0) ? dac_pat_data_0[16*c +: 16] : dac_pat_data_1[16*c +: 16];
          4'd2:      smp = dma_data[16*(2*c+k) +: 16];
          4'd4, 4'd5: smp = (k == 0) ? w[31:16] : w[15:0];
          4'd11:     smp = m_ramp[c] + 16'(k);
          default:   smp = 16'h0000;
        endcase
        exp[16*(2*c+k) +: 16] = smp;
      end
      if (v) begin
        if (s == 4'd4)  m_pn7[c]  = t7;
        if (s == 4'd5)  m_pn15[c] = t15;
        if (s == 4'd11) m_ramp[c] = m_ramp[c] + 16'd2;
      end
    end
  endtask

  // Apply one cycle of the current inputs, then compare the registered result with the model.
  task automatic cycle(input logic v, input logic chk, input string tag);
    logic [63:0] e;
    dac_valid = v;
    model_step(v, e);
    @(posedge link_clk);
    #1;
    if (chk) begin
      check_eq(tag, dac_data, e);
      check_eq({tag, "_vld"}, {63'd0, dac_valid_out}, {63'd0, v});
    end
  endtask

  initial begin
    dac_rst        = 1'b1;
    dac_valid      = 1'b0;
    dac_data_sel   = 8'h00;
    dac_dds_format = 1'b0;
    dac_pat_data_0 = '0;
    dac_pat_data_1 = '0;
    dds_data       = '0;
    dma_data       = '0;
    model_reset();
    repeat (2) @(posedge link_clk);
    #1;
    check_eq("rst_data", dac_data, 64'd0);
    check_eq("rst_vld", {63'd0, dac_valid_out}, 64'd0);
    @(negedge link_clk);
    dac_rst = 1'b0;

    // PN7 on ch0, PN15 on ch1: first words match hand-derived seeds
    dac_data_sel = {4'd5, 4'd4};
    cycle(1'b1, 1'b1, "pn_first");
    check_eq("pn7_seed_word", {48'd0, dac_data[15:0]}, 64'h020C);
    check_eq("pn15_seed_word", {48'd0, dac_data[47:32]}, 64'h0002);
    for (int i = 0; i < 200; i++) cycle(1'b1, 1'b1, "pn_run");

    // Asynchronous reset in the middle of the stream
    #2 dac_rst = 1'b1;
    #1;
    check_eq("midrst_data", dac_data, 64'd0);
    check_eq("midrst_vld", {63'd0, dac_valid_out}, 64'd0);
    @(posedge link_clk);
    @(negedge link_clk);
    dac_rst = 1'b0;
    model_reset();
    cycle(1'b1, 1'b1, "pn_after_rst");
    check_eq("pn7_after_rst", {48'd0, dac_data[15:0]}, 64'h020C);

    // Hold: generators advance only on valid cycles
    for (int i = 0; i < 20; i++) cycle(((i % 2) == 0), 1'b1, "hold");

    // Reseed ch0 through 4->3->4 while ch1 PN15 keeps running
    dac_data_sel = {4'd5, 4'd3};
    repeat (3) cycle(1'b1, 1'b1, "ch0_zero");
    dac_data_sel = {4'd5, 4'd4};
    cycle(1'b1, 1'b1, "reseed");
    check_eq("reseed_pn7", {48'd0, dac_data[15:0]}, 64'h020C);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, "reseed_run");

    // Pattern words are output whether or not dac_valid is high
    dac_data_sel   = {4'd1, 4'd1};
    dac_pat_data_0 = 32'hA5A5_A5A5;
    dac_pat_data_1 = 32'h5A5A_5A5A;
    cycle(1'b0, 1'b1, "pat_novalid");
    check_eq("pat_const0", dac_data, 64'h5A5A_A5A5_5A5A_A5A5);
    cycle(1'b1, 1'b1, "pat_valid");
    check_eq("pat_const1", dac_data, 64'h5A5A_A5A5_5A5A_A5A5);

    // DDS in offset-binary and two's-complement formats
    dac_data_sel   = {4'd0, 4'd0};
    dds_data       = 64'h7FFF_0001_FFFF_1234;
    dac_dds_format = 1'b0;
    cycle(1'b1, 1'b1, "dds_fmt0");
    check_eq("dds_fmt0_const", dac_data, 64'hFFFF_8001_7FFF_9234);
    dac_dds_format = 1'b1;
    cycle(1'b1, 1'b1, "dds_fmt1");
    check_eq("dds_fmt1_const", dac_data, 64'h7FFF_0001_FFFF_1234);

    // DMA pass-through on ch0; reserved code on ch1 produces zero
    dac_data_sel = {4'd7, 4'd2};
    dma_data     = 64'h1111_2222_CAFE_BEEF;
    cycle(1'b1, 1'b1, "dma");
    check_eq("dma_const", dac_data, 64'h0000_0000_CAFE_BEEF);
    dac_data_sel = {4'd15, 4'd6};
    cycle(1'b1, 1'b1, "reserved");
    check_eq("reserved_const", dac_data, 64'd0);

    // Ramp on ch0, including wrap from 0xFFFF to 0x0000
    dac_data_sel = {4'd3, 4'd11};
    cycle(1'b1, 1'b1, "ramp0");
    check_eq("ramp0_const", dac_data, 64'h0000_0000_0001_0000);
    cycle(1'b1, 1'b1, "ramp1");
    check_eq("ramp1_const", dac_data, 64'h0000_0000_0003_0002);
    for (int i = 0; i < 32765; i++) cycle(1'b1, 1'b0, "ramp_fill");
    cycle(1'b1, 1'b1, "ramp_top");
    check_eq("ramp_top_const", dac_data, 64'h0000_0000_FFFF_FFFE);
    cycle(1'b1, 1'b1, "ramp_wrap");
    check_eq("ramp_wrap_const", dac_data, 64'h0000_0000_0001_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
